// File: rtl/pio_test_pio_in.sv
// pio_test_pio_in: Avalon-MM input PIO with a two-flop input synchronizer,
// rising-edge capture with write-1-to-clear, and a warm-up window that
// suppresses false captures right after reset.
// Optional feature macro: PIO_IN_IRQ_EN adds the irqmask register (addr 2)
// and the level interrupt output irq = |(edgecapture & irqmask).
module pio_test_pio_in #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata
`ifdef PIO_IN_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecapture;
  logic [1:0]       r_warmup;
  logic             w_armed;
  logic             w_write;
  logic [WIDTH-1:0] w_edge_set;
  logic [WIDTH-1:0] w_ec_clr;
  logic [31:0]      w_readdata;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of writedata are meaningful; fold the rest away.
  assign w_unused_wdata = ^writedata;

  assign w_write    = chipselect & ~write_n;
  assign w_armed    = (r_warmup == 2'd3);
  assign w_edge_set = r_sync2 & ~r_prev & {WIDTH{w_armed}};
  assign w_ec_clr   = (w_write && (address == 2'd3)) ? writedata[WIDTH-1:0]
                                                     : {WIDTH{1'b0}};

  // Two-flop synchronizer for the asynchronous inputs plus a history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
      r_prev  <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Warm-up counter: arms edge detection only once the sync chain holds real data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warmup <= 2'd0;
    end else if (r_warmup != 2'd3) begin
      r_warmup <= r_warmup + 2'd1;
    end
  end

  // Edge capture: write-1-to-clear, with a same-cycle set taking precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edgecapture <= {WIDTH{1'b0}};
    end else begin
      r_edgecapture <= (r_edgecapture & ~w_ec_clr) | w_edge_set;
    end
  end

`ifdef PIO_IN_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;

  // Interrupt mask register, written at address 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= {WIDTH{1'b0}};
    end else if (w_write && (address == 2'd2)) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(r_edgecapture & r_irqmask);
`endif

  // Zero-latency read mux, zero-extended; independent of chipselect.
  always_comb begin
    w_readdata = 32'd0;
    case (address)
      2'd0: w_readdata[WIDTH-1:0] = r_sync2;
      2'd1: w_readdata = 32'd0;
`ifdef PIO_IN_IRQ_EN
      2'd2: w_readdata[WIDTH-1:0] = r_irqmask;
`else
      2'd2: w_readdata = 32'd0;
`endif
      2'd3: w_readdata[WIDTH-1:0] = r_edgecapture;
      default: w_readdata = 32'd0;
    endcase
  end

  assign readdata = w_readdata;

endmodule

// File: tb/tb_pio_test_pio_in.sv
// Testbench for pio_test_pio_in (WIDTH = 8). Directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model that
// is expressed as "sample history" rules rather than flop-by-flop logic.
`timescale 1ns/1ps
module tb_pio_test_pio_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp;
  int n_err;

  // Reference model state.
  int         m_edges;   // clock edges since reset released
  logic [7:0] m_s1;      // input sampled one edge ago
  logic [7:0] m_s2;      // input sampled two edges ago
  logic [7:0] m_s3;      // input sampled three edges ago
  logic [7:0] m_ec;
  logic [7:0] m_mask;

  pio_test_pio_in #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata)
`ifdef PIO_IN_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

`ifndef PIO_IN_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 2'd0) v[7:0] = m_s2;
`ifdef PIO_IN_IRQ_EN
    if (a == 2'd2) v[7:0] = m_mask;
`endif
    if (a == 2'd3) v[7:0] = m_ec;
    return v;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, settle 1ns.
  task automatic tick(input logic rst, input logic [1:0] a, input logic cs,
                      input logic wn, input logic [31:0] wd, input logic [7:0] inp);
    logic [7:0] set_v;
    @(negedge clk);
    reset = rst; address = a; chipselect = cs; write_n = wn;
    writedata = wd; in_port = inp;
    @(posedge clk);
    if (rst) begin
      m_edges = 0; m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00;
      m_ec = 8'h00; m_mask = 8'h00;
    end else begin
      m_edges++;
      // A rise is seen when the value synchronized two edges ago is 1 and the
      // one before it was 0, but only from the fourth edge after reset.
      set_v = (m_edges >= 4) ? (m_s2 & ~m_s3) : 8'h00;
      if (cs && !wn && a == 2'd3) m_ec = m_ec & ~wd[7:0];
      m_ec = m_ec | set_v;
`ifdef PIO_IN_IRQ_EN
      if (cs && !wn && a == 2'd2) m_mask = wd[7:0];
`endif
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = inp;
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] inp, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0, 1'b1, 32'd0, inp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [7:0] inp);
    tick(1'b0, a, 1'b1, 1'b0, wd, inp);
  endtask

  task automatic rd_exp(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address = a;
    #1;
    check_eq(tag, readdata, exp);
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < 4; a++) rd_exp(a[1:0], tag, model_read(a[1:0]));
    check_eq({tag, "_irq"}, {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_edges = 0; m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00;
    m_ec = 8'h00; m_mask = 8'h00;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = 8'hA5;

    // Reset with inputs already high: everything reads zero.
    tick(1'b1, 2'd0, 1'b0, 1'b1, 32'd0, 8'hA5);
    tick(1'b1, 2'd0, 1'b0, 1'b1, 32'd0, 8'hA5);
    rd_exp(2'd0, "rst_a0", 32'd0);
    rd_exp(2'd1, "rst_a1", 32'd0);
    rd_exp(2'd2, "rst_a2", 32'd0);
    rd_exp(2'd3, "rst_a3", 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);

    // Inputs held high through reset: data visible, no capture.
    idle(8'hA5, 6);
    rd_exp(2'd0, "a5_data", 32'h0000_00A5);
    rd_exp(2'd3, "a5_noedge", 32'd0);
    rd_all("a5_model");

    // 0x00 -> 0x81 latency.
    idle(8'h00, 4);
    rd_exp(2'd3, "zero_ec", 32'd0);
    idle(8'h81, 1);                       // edge k
    rd_exp(2'd0, "k_data", 32'd0);
    idle(8'h81, 1);                       // edge k+1
    rd_exp(2'd0, "k1_data", 32'h81);
    rd_exp(2'd3, "k1_ec", 32'd0);
    idle(8'h81, 1);                       // edge k+2
    rd_exp(2'd3, "k2_ec", 32'h81);
    idle(8'h00, 4);
    rd_exp(2'd3, "fall_keeps", 32'h81);
    rd_all("seq81_model");

    // Write-1-to-clear.
    wr(2'd3, 32'h01, 8'h00);
    rd_exp(2'd3, "w1c_bit0", 32'h80);
    wr(2'd3, 32'h00, 8'h00);
    rd_exp(2'd3, "w0_noop", 32'h80);
    wr(2'd1, 32'hFF, 8'h00);
    rd_exp(2'd1, "rsvd_ign", 32'd0);

    // Set wins over a coincident clear on bit 2.
    idle(8'h04, 2);
    wr(2'd3, 32'h04, 8'h04);
    rd_exp(2'd3, "set_wins", 32'h84);

    // Interrupt behaviour (mask register only exists with the feature).
    wr(2'd3, 32'hFF, 8'h04);
    rd_exp(2'd3, "clr_all", 32'd0);
    wr(2'd2, 32'h02, 8'h04);
`ifdef PIO_IN_IRQ_EN
    rd_exp(2'd2, "mask_rd", 32'h02);
`else
    rd_exp(2'd2, "mask_absent", 32'd0);
`endif
    idle(8'h06, 2);
    check_eq("irq_k1", {31'd0, irq}, 32'd0);
    idle(8'h06, 1);
    rd_exp(2'd3, "ec_bit1", 32'h02);
`ifdef PIO_IN_IRQ_EN
    check_eq("irq_k2", {31'd0, irq}, 32'd1);
`endif
    wr(2'd3, 32'h02, 8'h06);
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
    idle(8'h07, 3);
    rd_exp(2'd3, "ec_bit0", 32'h01);
    check_eq("irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'hFF, 8'h07);

    // Mid-operation reset beats a pending write and captured edges.
    idle(8'h00, 3);
    idle(8'hFF, 3);
    rd_exp(2'd3, "ec_ff", 32'hFF);
    tick(1'b1, 2'd2, 1'b1, 1'b0, 32'hFF, 8'hFF);
    rd_exp(2'd0, "mrst_a0", 32'd0);
    rd_exp(2'd2, "mrst_a2", 32'd0);
    rd_exp(2'd3, "mrst_a3", 32'd0);
    check_eq("mrst_irq", {31'd0, irq}, 32'd0);
    idle(8'hFF, 8);
    rd_exp(2'd3, "hold_ff_noedge", 32'd0);
    rd_exp(2'd0, "hold_ff_data", 32'hFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0]  inp;
      logic        rst;
      logic        cs;
      logic        wn;
      logic [1:0]  a;
      logic [31:0] wd;
      inp = ($urandom_range(0, 2) == 0) ? 8'($urandom) : in_port;
      rst = ($urandom_range(0, 49) == 0);
      cs  = 1'($urandom);
      wn  = ($urandom_range(0, 2) != 0);
      a   = 2'($urandom);
      wd  = $urandom;
      tick(rst, a, cs, wn, wd, inp);
      rd_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_test_pio_in.md
PIO_TEST_PIO_IN -- requirements
Module: pio_test_pio_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the input port width (1..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-003 The block SHALL have port reset  input  1  the reset, synchronous and active-high.
REQ-004 The block SHALL have port address  input  2  the Avalon-MM slave word address.
REQ-005 The block SHALL have port chipselect  input  1  the slave select.
REQ-006 The block SHALL have port write_n  input  1  the active-low write strobe, qualified by chipselect.
REQ-007 The block SHALL have port writedata  input  32  the write data.
REQ-008 The block SHALL have port in_port  input  WIDTH  the asynchronous external inputs.
REQ-009 The block SHALL have port readdata  output  32  the read data; zero wait states, read latency 0.
REQ-010 The block SHALL have port irq  output  1  the level interrupt, present only when PIO_IN_IRQ_EN is defined.

Function
REQ-011 The block SHALL pass in_port through a two-flop synchronizer (sync1, sync2), followed by a history flop prev <= sync2.
REQ-012 The register map SHALL be: addr 0 data (RO, = sync2); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW, WIDTH bits); addr 3 edgecapture (read, write-1-to-clear).
REQ-013 readdata SHALL be the combinational mux of the addressed register, zero-extended to 32 bits; it is independent of chipselect.
REQ-014 A write SHALL occur on a clock edge when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-015 Latency: an in_port transition set up before edge k SHALL be visible at addr 0 after edge k+1.
REQ-016 Edge detection SHALL be rising-edge only: edgecapture[i] sets on an edge where sync2[i]=1, prev[i]=0, and armed=1.
REQ-017 An in_port rising transition set up before edge k SHALL set edgecapture after edge k+2.
REQ-018 An edgecapture bit SHALL remain set until cleared by writing 1 to that bit at addr 3; writing 0 leaves the bit unchanged.
REQ-019 When a set condition and a clear write for the same bit coincide, set SHALL win and the bit stays 1.
REQ-020 A 2-bit warm-up counter SHALL count 0->3 after reset release and saturate at 3; armed = (counter==3).
REQ-021 Inputs held high through reset SHALL NOT produce an edgecapture.
REQ-022 Pulses narrower than one clk period SHALL be undefined, with no capture guaranteed.

Reset
REQ-023 On reset SHALL clear sync1, sync2, prev, irqmask, edgecapture and the warm-up counter to 0.
REQ-024 A reset asserted mid-operation SHALL take priority over any same-cycle write or edge set.
REQ-025 After reset, readdata SHALL read 0 at all addresses until inputs propagate, and irq SHALL be 0.

Configuration
REQ-026 With PIO_IN_IRQ_EN defined, irq SHALL equal |(edgecapture & irqmask), driven from registers with no added latency.
REQ-027 With PIO_IN_IRQ_EN undefined, the irq port and irqmask register SHALL be absent; addr 2 reads 0 and writes are ignored; edge capture is unchanged.

Verification
REQ-028 The bench SHALL cover: in_port=8'hA5 from reset, after warm-up -> addr 0 reads 32'h000000A5, addr 3 reads 0.
REQ-029 The bench SHALL cover: in_port 0x00->0x81 before edge k -> addr 0 = 0x81 after k+1; addr 3 = 0x81 after k+2; in_port back to 0 leaves addr 3 = 0x81.
REQ-030 The bench SHALL cover: edgecapture=0x81; write 0x01 to addr 3 -> reads 0x80; write 0x00 -> still 0x80.
REQ-031 The bench SHALL cover: write 0x04 to addr 3 on the same edge bit 2 rising is detected -> addr 3 bit 2 reads 1.
REQ-032 The bench SHALL cover (PIO_IN_IRQ_EN): irqmask=0x02, bit 1 rises -> irq=1 after k+2; bit 0 rises only -> irq stays 0; clear bit 1 -> irq=0 next cycle.
REQ-033 The bench SHALL cover: reset asserted for 1 cycle while edgecapture=0xFF and a write is pending -> all registers 0; in_port held 0xFF -> no capture.
